// File: rtl/vc_sched_pkg.sv
// Shared definitions for the VC-stage scheduler: state encoding, field widths
// and bit positions inside the {vc0,vc1,d0,d1} FIFO error vector.
package vc_sched_pkg;

  localparam int VC_TW = 4;
  localparam int D_TW  = 2;
  localparam int W_W   = 3;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  localparam int ERR_VC0 = 3;
  localparam int ERR_VC1 = 2;
  localparam int ERR_D0  = 1;
  localparam int ERR_D1  = 0;

endpackage

// File: rtl/vc_sched_ctrl_wrr_arb2.sv
// Two-way weighted round-robin arbiter: the owner keeps the grant for up to
// weight consecutive cycles, then yields to the other VC if it is eligible.
module wrr_arb2
  import vc_sched_pkg::*;
#(
  parameter int WW = W_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          elig0,
  input  logic          elig1,
  input  logic [WW-1:0] w0,
  input  logic [WW-1:0] w1,
  output logic          grant0,
  output logic          grant1,
  output logic          owner,
  output logic [WW-1:0] credit
);

  logic [WW-1:0] wt;
  logic [WW-1:0] eff_wt;
  logic          elig_own;
  logic          elig_oth;
  logic          keep;
  logic          swap;
  logic          regrant;
  logic          grant_own;

  // credit == 0 means no grant has been issued yet: the owner has no quota,
  // so the first grant after reset goes to the VC opposite last_grant.
  always_comb begin
    wt       = owner ? w1 : w0;
    eff_wt   = (wt == '0) ? WW'(1) : wt;
    elig_own = owner ? elig1 : elig0;
    elig_oth = owner ? elig0 : elig1;
    keep     = 1'b0;
    swap     = 1'b0;
    regrant  = 1'b0;
    if (elig_own && (credit != '0) && (credit < eff_wt)) keep = 1'b1;
    else if (elig_oth)                                    swap = 1'b1;
    else if (elig_own)                                    regrant = 1'b1;
    grant_own = keep | regrant;
    grant0    = owner ? swap : grant_own;
    grant1    = owner ? grant_own : swap;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner  <= 1'b1;
      credit <= '0;
    end else if (en) begin
      if (keep) begin
        credit <= credit + WW'(1);
      end else if (swap) begin
        owner  <= ~owner;
        credit <= WW'(1);
      end else if (regrant) begin
        credit <= WW'(1);
      end
    end
  end

endmodule

// File: rtl/vc_sched_ctrl.sv
// VC-stage controller: top-level state machine, threshold latches, and the
// weighted round-robin pop issue to the VC FIFOs under D-FIFO backpressure.
module vc_sched_ctrl
  import vc_sched_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic [VC_TW-1:0] cfg_afVC,
  input  logic [VC_TW-1:0] cfg_aeVC,
  input  logic [D_TW-1:0]  cfg_afD,
  input  logic [D_TW-1:0]  cfg_aeD,
  input  logic [W_W-1:0]   cfg_w0,
  input  logic [W_W-1:0]   cfg_w1,
  input  logic             fifo_empty_vc0,
  input  logic             fifo_empty_vc1,
  input  logic             head_dest_vc0,
  input  logic             head_dest_vc1,
  input  logic             fifo_pause_d0,
  input  logic             fifo_pause_d1,
  input  logic [3:0]       fifo_error,
  output logic [VC_TW-1:0] afVC_o,
  output logic [VC_TW-1:0] aeVC_o,
  output logic [D_TW-1:0]  afD_o,
  output logic [D_TW-1:0]  aeD_o,
  output logic             pop_vc0,
  output logic             pop_vc1,
  output logic             pop_delay_vc0,
  output logic             pop_delay_vc1,
  output logic [2:0]       state,
  output logic             idle,
  output logic             error
);

  state_t         st;
  state_t         st_nxt;
  logic [W_W-1:0] w0_q;
  logic [W_W-1:0] w1_q;
  logic           any_err;
  logic           elig0;
  logic           elig1;
  logic           pop_en;
  logic           grant0;
  logic           grant1;
  logic           arb_owner;
  logic [W_W-1:0] arb_credit;

  assign any_err = |fifo_error;
  assign elig0   = !fifo_empty_vc0 && !(head_dest_vc0 ? fifo_pause_d1 : fifo_pause_d0);
  assign elig1   = !fifo_empty_vc1 && !(head_dest_vc1 ? fifo_pause_d1 : fifo_pause_d0);

  // Pops are only issued in ACTIVE and are suppressed in any cycle that is
  // about to leave ACTIVE for ERROR or INIT.
  assign pop_en  = !reset && (st == ST_ACTIVE) && !any_err && !init;
  assign pop_vc0 = pop_en & grant0;
  assign pop_vc1 = pop_en & grant1;
  assign state   = st;

  wrr_arb2 #(.WW(W_W)) u_arb (
    .clk    (clk),
    .reset  (reset),
    .en     (pop_en),
    .elig0  (elig0),
    .elig1  (elig1),
    .w0     (w0_q),
    .w1     (w1_q),
    .grant0 (grant0),
    .grant1 (grant1),
    .owner  (arb_owner),
    .credit (arb_credit)
  );

  // Error outranks init, which outranks normal flow.
  always_comb begin
    st_nxt = st;
    case (st)
      ST_RESET:  st_nxt = ST_INIT;
      ST_INIT:   st_nxt = init ? ST_INIT : ST_IDLE;
      ST_IDLE: begin
        if (any_err)                             st_nxt = ST_ERROR;
        else if (init)                           st_nxt = ST_INIT;
        else if (!fifo_empty_vc0 || !fifo_empty_vc1) st_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (any_err)                             st_nxt = ST_ERROR;
        else if (init)                           st_nxt = ST_INIT;
        else if (fifo_empty_vc0 && fifo_empty_vc1) st_nxt = ST_IDLE;
      end
      ST_ERROR:  st_nxt = ST_ERROR;
      default:   st_nxt = ST_ERROR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st            <= ST_RESET;
      idle          <= 1'b0;
      error         <= 1'b0;
      afVC_o        <= '0;
      aeVC_o        <= '0;
      afD_o         <= '0;
      aeD_o         <= '0;
      w0_q          <= '0;
      w1_q          <= '0;
      pop_delay_vc0 <= 1'b0;
      pop_delay_vc1 <= 1'b0;
    end else begin
      st            <= st_nxt;
      idle          <= (st_nxt == ST_IDLE);
      error         <= (st_nxt == ST_ERROR);
      pop_delay_vc0 <= pop_vc0;
      pop_delay_vc1 <= pop_vc1;
      if ((st == ST_INIT) && init) begin
        afVC_o <= cfg_afVC;
        aeVC_o <= cfg_aeVC;
        afD_o  <= cfg_afD;
        aeD_o  <= cfg_aeD;
        w0_q   <= cfg_w0;
        w1_q   <= cfg_w1;
      end
    end
  end

endmodule

// File: tb/tb_vc_sched_ctrl.sv
// Directed bench for vc_sched_ctrl: a vector table for arbitration, backpressure
// and error entry, plus hand sequences for configuration, init and weight-0.
module tb_vc_sched_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       init;
  logic [3:0] cfg_afVC, cfg_aeVC;
  logic [1:0] cfg_afD, cfg_aeD;
  logic [2:0] cfg_w0, cfg_w1;
  logic       fifo_empty_vc0, fifo_empty_vc1;
  logic       head_dest_vc0, head_dest_vc1;
  logic       fifo_pause_d0, fifo_pause_d1;
  logic [3:0] fifo_error;
  logic [3:0] afVC_o, aeVC_o;
  logic [1:0] afD_o, aeD_o;
  logic       pop_vc0, pop_vc1, pop_delay_vc0, pop_delay_vc1;
  logic [2:0] state;
  logic       idle, error;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vc_sched_ctrl dut (
    .clk(clk), .reset(reset), .init(init),
    .cfg_afVC(cfg_afVC), .cfg_aeVC(cfg_aeVC), .cfg_afD(cfg_afD), .cfg_aeD(cfg_aeD),
    .cfg_w0(cfg_w0), .cfg_w1(cfg_w1),
    .fifo_empty_vc0(fifo_empty_vc0), .fifo_empty_vc1(fifo_empty_vc1),
    .head_dest_vc0(head_dest_vc0), .head_dest_vc1(head_dest_vc1),
    .fifo_pause_d0(fifo_pause_d0), .fifo_pause_d1(fifo_pause_d1),
    .fifo_error(fifo_error),
    .afVC_o(afVC_o), .aeVC_o(aeVC_o), .afD_o(afD_o), .aeD_o(aeD_o),
    .pop_vc0(pop_vc0), .pop_vc1(pop_vc1),
    .pop_delay_vc0(pop_delay_vc0), .pop_delay_vc1(pop_delay_vc1),
    .state(state), .idle(idle), .error(error)
  );

  typedef struct {
    logic       empty0, empty1, dest0, dest1, pause0, pause1;
    logic [3:0] err;
    logic [2:0] exp_state;
    logic       exp_pop0, exp_pop1, exp_pd0, exp_pd1, exp_error;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Sampled mid-cycle: registered outputs from the last edge, pops from current inputs.
  task automatic check_io(input string tag, input int st, input int p0, input int p1,
                          input int d0, input int d1);
    @(negedge clk);
    check({tag, ".state"}, int'(state), st);
    check({tag, ".pop0"}, int'(pop_vc0), p0);
    check({tag, ".pop1"}, int'(pop_vc1), p1);
    check({tag, ".pd0"}, int'(pop_delay_vc0), d0);
    check({tag, ".pd1"}, int'(pop_delay_vc1), d1);
  endtask

  task automatic set_vcs(input logic e0, input logic e1, input logic h0, input logic h1,
                         input logic p0, input logic p1);
    fifo_empty_vc0 = e0; fifo_empty_vc1 = e1;
    head_dest_vc0  = h0; head_dest_vc1  = h1;
    fifo_pause_d0  = p0; fifo_pause_d1  = p1;
  endtask

  task automatic configure(input logic [3:0] af, input logic [3:0] ae, input logic [1:0] afd,
                           input logic [1:0] aed, input logic [2:0] w0, input logic [2:0] w1);
    cfg_afVC = af; cfg_aeVC = ae; cfg_afD = afd; cfg_aeD = aed; cfg_w0 = w0; cfg_w1 = w1;
  endtask

  // Reset two cycles, then RESET -> INIT (latch cfg) -> IDLE.
  task automatic reset_and_init(input string tag);
    reset = 1'b1; init = 1'b0;
    next_cycle(); next_cycle();
    @(negedge clk);
    check({tag, ".rst_state"}, int'(state), 0);
    check({tag, ".rst_afVC"}, int'(afVC_o), 0);
    check({tag, ".rst_idle_err"}, int'({idle, error}), 0);
    check({tag, ".rst_pops"}, int'({pop_vc0, pop_vc1, pop_delay_vc0, pop_delay_vc1}), 0);
    @(posedge clk); #1;
    reset = 1'b0; init = 1'b1;
    next_cycle();
    @(negedge clk);
    check({tag, ".init_state"}, int'(state), 1);
    next_cycle();
    init = 1'b0;
    next_cycle();
    @(negedge clk);
    check({tag, ".idle_state"}, int'(state), 2);
    check({tag, ".idle_flag"}, int'(idle), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; init = 1'b0; fifo_error = '0;
    configure(4'd12, 4'd2, 2'd3, 2'd1, 3'd2, 3'd1);
    set_vcs(1, 1, 0, 0, 0, 0);
    #1;

    // Sequence 1: reset, latch thresholds, reach IDLE.
    reset_and_init("cfg");
    check("cfg.afVC", int'(afVC_o), 12);
    check("cfg.aeVC", int'(aeVC_o), 2);
    check("cfg.afD", int'(afD_o), 3);
    check("cfg.aeD", int'(aeD_o), 1);

    // Table: w0=2, w1=1. Rows 0-6 round robin, 7-11 backpressure, 12-14 error.
    //            e0 e1 h0 h1 p0 p1 err    st p0 p1 d0 d1 er
    vecs[0]  = '{0, 0, 0, 1, 0, 0, 4'h0, 2, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 0, 0, 1, 0, 0, 4'h0, 3, 1, 0, 0, 0, 0};
    vecs[2]  = '{0, 0, 0, 1, 0, 0, 4'h0, 3, 1, 0, 1, 0, 0};
    vecs[3]  = '{0, 0, 0, 1, 0, 0, 4'h0, 3, 0, 1, 1, 0, 0};
    vecs[4]  = '{0, 0, 0, 1, 0, 0, 4'h0, 3, 1, 0, 0, 1, 0};
    vecs[5]  = '{0, 0, 0, 1, 0, 0, 4'h0, 3, 1, 0, 1, 0, 0};
    vecs[6]  = '{0, 0, 0, 1, 0, 0, 4'h0, 3, 0, 1, 1, 0, 0};
    vecs[7]  = '{0, 0, 1, 0, 0, 1, 4'h0, 3, 0, 1, 0, 1, 0};
    vecs[8]  = '{0, 0, 1, 0, 0, 1, 4'h0, 3, 0, 1, 0, 1, 0};
    vecs[9]  = '{0, 0, 1, 0, 0, 0, 4'h0, 3, 1, 0, 0, 1, 0};
    vecs[10] = '{0, 0, 1, 0, 0, 0, 4'h0, 3, 1, 0, 1, 0, 0};
    vecs[11] = '{0, 0, 1, 0, 0, 0, 4'h0, 3, 0, 1, 1, 0, 0};
    vecs[12] = '{0, 0, 0, 1, 0, 0, 4'h4, 3, 0, 0, 0, 1, 0};
    vecs[13] = '{0, 0, 0, 1, 0, 0, 4'h0, 4, 0, 0, 0, 0, 1};
    vecs[14] = '{0, 0, 0, 1, 0, 0, 4'h0, 4, 0, 0, 0, 0, 1};

    for (int i = 0; i < 15; i++) begin
      set_vcs(vecs[i].empty0, vecs[i].empty1, vecs[i].dest0, vecs[i].dest1,
              vecs[i].pause0, vecs[i].pause1);
      fifo_error = vecs[i].err;
      check_io($sformatf("vec%0d", i), int'(vecs[i].exp_state), int'(vecs[i].exp_pop0),
               int'(vecs[i].exp_pop1), int'(vecs[i].exp_pd0), int'(vecs[i].exp_pd1));
      check($sformatf("vec%0d.error", i), int'(error), int'(vecs[i].exp_error));
      check($sformatf("vec%0d.both", i), int'(pop_vc0 & pop_vc1), 0);
      @(posedge clk); #1;
    end

    // Sequence 2: reset out of ERROR, then init while ACTIVE.
    set_vcs(1, 1, 0, 0, 0, 0);
    configure(4'd12, 4'd2, 2'd3, 2'd1, 3'd2, 3'd1);
    reset_and_init("re");
    set_vcs(0, 1, 0, 0, 0, 0);
    check_io("act.idle", 2, 0, 0, 0, 0);
    @(posedge clk); #1;
    check_io("act.pop", 3, 1, 0, 0, 0);
    @(posedge clk); #1;
    init = 1'b1;
    configure(4'd9, 4'd5, 2'd2, 2'd0, 3'd0, 3'd3);
    check_io("act.init", 3, 0, 0, 1, 0);
    @(posedge clk); #1;
    check_io("init.enter", 1, 0, 0, 0, 0);
    @(posedge clk); #1;
    init = 1'b0;
    next_cycle();
    @(negedge clk);
    check("reinit.state", int'(state), 2);
    check("reinit.afVC", int'(afVC_o), 9);
    check("reinit.aeVC", int'(aeVC_o), 5);
    check("reinit.afD", int'(afD_o), 2);
    check("reinit.aeD", int'(aeD_o), 0);
    @(posedge clk); #1;

    // Sequence 3: w0=0 acts as 1; sole eligible VC0 is re-granted every cycle.
    check_io("w0.enter", 3, 1, 0, 0, 0);
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      check_io($sformatf("w0.c%0d", k + 1), 3, 1, 0, 1, 0);
      @(posedge clk); #1;
    end

    // Mid-operation reset drops the pending pop_delay.
    reset = 1'b1;
    next_cycle();
    @(negedge clk);
    check("midrst.state", int'(state), 0);
    check("midrst.pd0", int'(pop_delay_vc0), 0);
    check("midrst.pop0", int'(pop_vc0), 0);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, tests run %0d", n_tests);
    $fatal(1, "timeout");
  end

endmodule
